// File: rtl/hl_mem_unit_pkg.sv
// Shared definitions for the HL memory-operand sequencer: register codes,
// request opcodes, FSM states and opcode decode helpers.
package hl_mem_unit_pkg;

  typedef enum logic [2:0] {
    REG_A    = 3'b000,
    REG_B    = 3'b001,
    REG_C    = 3'b010,
    REG_D    = 3'b011,
    REG_E    = 3'b100,
    REG_H    = 3'b101,
    REG_L    = 3'b110,
    REG_RSVD = 3'b111
  } reg_e;

  typedef enum logic [2:0] {
    OP_RD     = 3'b000,
    OP_WR     = 3'b001,
    OP_RD_INC = 3'b010,
    OP_WR_INC = 3'b011,
    OP_INX    = 3'b100,
    OP_DCX    = 3'b101,
    OP_RD_DEC = 3'b110,
    OP_WR_DEC = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_MEM  = 3'b001,
    ST_WB_L = 3'b010,
    ST_WB_H = 3'b011,
    ST_DONE = 3'b100
  } state_e;

  function automatic logic op_is_mem(input op_e op);
    case (op)
      OP_INX, OP_DCX: op_is_mem = 1'b0;
      default:        op_is_mem = 1'b1;
    endcase
  endfunction

  function automatic logic op_is_wr(input op_e op);
    case (op)
      OP_WR, OP_WR_INC, OP_WR_DEC: op_is_wr = 1'b1;
      default:                     op_is_wr = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_rd(input op_e op);
    case (op)
      OP_RD, OP_RD_INC, OP_RD_DEC: op_is_rd = 1'b1;
      default:                     op_is_rd = 1'b0;
    endcase
  endfunction

  // Every op except plain RD/WR writes an updated HL back
  function automatic logic op_is_upd(input op_e op);
    case (op)
      OP_RD, OP_WR: op_is_upd = 1'b0;
      default:      op_is_upd = 1'b1;
    endcase
  endfunction

  function automatic logic op_is_dec(input op_e op);
    case (op)
      OP_DCX, OP_RD_DEC, OP_WR_DEC: op_is_dec = 1'b1;
      default:                      op_is_dec = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hl_mem_unit_if.sv
// Request, memory, register-file and response signals of the HL sequencer.
// slave = the sequencer, master = the control unit / memory / register-file side.
interface hl_mem_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [7:0]  req_wdata;
  logic [15:0] hl_in;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        rf_we;
  logic [2:0]  rf_write_sel;
  logic [7:0]  rf_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_op, req_wdata, hl_in, mem_rdata, mem_ready,
    output req_ready, mem_addr, mem_wdata, mem_rd, mem_wr,
           rf_we, rf_write_sel, rf_data, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_op, req_wdata, hl_in, mem_rdata, mem_ready,
    input  req_ready, mem_addr, mem_wdata, mem_rd, mem_wr,
           rf_we, rf_write_sel, rf_data, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/hl_incdec.sv
// 16-bit HL increment/decrement, wrapping modulo 2^16.
module hl_incdec (
  input  logic [15:0] hl_i,
  input  logic        dec_i,
  output logic [15:0] hl_o
);

  assign hl_o = dec_i ? (hl_i - 16'd1) : (hl_i + 16'd1);

endmodule

// File: rtl/hl_mem_unit.sv
// 8085-style M-operand sequencer: memory access at [HL], optional HL +/-1,
// and writeback of the new HL to the register file as L then H.
module hl_mem_unit
  import hl_mem_unit_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  hl_mem_unit_if.slave bus
);

  state_e             state_q;
  op_e                op_q;
  logic [7:0]         wdata_q;
  logic [7:0]         rdata_q;
  logic [15:0]        hl_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               req_ready_q;
  logic [15:0]        mem_addr_q;
  logic [7:0]         mem_wdata_q;
  logic               mem_rd_q;
  logic               mem_wr_q;
  logic               rf_we_q;
  logic [2:0]         rf_sel_q;
  logic [7:0]         rf_data_q;
  logic               rsp_valid_q;
  logic [7:0]         rsp_data_q;
  logic               rsp_err_q;

  op_e                req_op_s;
  logic [15:0]        inc_in_s;
  logic               inc_dec_s;
  logic [15:0]        hl_next_s;
  logic               wait_last_s;

  assign req_op_s    = op_e'(bus.req_op);
  // INX/DCX write L on the accept edge, so in IDLE the adder sees the live request
  assign inc_in_s    = (state_q == ST_IDLE) ? bus.hl_in : hl_q;
  assign inc_dec_s   = (state_q == ST_IDLE) ? op_is_dec(req_op_s) : op_is_dec(op_q);
  assign wait_last_s = (wait_q == WAIT_W'(MAX_WAIT - 1));

  hl_incdec u_incdec (
    .hl_i  (inc_in_s),
    .dec_i (inc_dec_s),
    .hl_o  (hl_next_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_RD;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      hl_q        <= 16'h0000;
      wait_q      <= '0;
      req_ready_q <= 1'b1;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_sel_q    <= 3'b000;
      rf_data_q   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      rf_we_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q        <= req_op_s;
            wdata_q     <= bus.req_wdata;
            hl_q        <= bus.hl_in;
            rdata_q     <= 8'h00;
            wait_q      <= '0;
            req_ready_q <= 1'b0;
            if (op_is_mem(req_op_s)) begin
              state_q     <= ST_MEM;
              mem_addr_q  <= bus.hl_in;
              mem_rd_q    <= ~op_is_wr(req_op_s);
              mem_wr_q    <= op_is_wr(req_op_s);
              mem_wdata_q <= op_is_wr(req_op_s) ? bus.req_wdata : 8'h00;
            end else begin
              state_q   <= ST_WB_L;
              rf_we_q   <= 1'b1;
              rf_sel_q  <= REG_L;
              rf_data_q <= hl_next_s[7:0];
            end
          end
        end
        ST_MEM: begin
          if (bus.mem_ready || wait_last_s) begin
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
          end
          if (bus.mem_ready) begin
            if (op_is_rd(op_q)) begin
              rdata_q <= bus.mem_rdata;
            end
            if (op_is_upd(op_q)) begin
              state_q   <= ST_WB_L;
              rf_we_q   <= 1'b1;
              rf_sel_q  <= REG_L;
              rf_data_q <= hl_next_s[7:0];
            end else begin
              state_q     <= ST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= op_is_rd(op_q) ? bus.mem_rdata : 8'h00;
              rsp_err_q   <= 1'b0;
            end
          end else if (wait_last_s) begin
            // Timeout: report the error and skip the HL writeback entirely
            state_q     <= ST_DONE;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_WB_L: begin
          state_q   <= ST_WB_H;
          rf_we_q   <= 1'b1;
          rf_sel_q  <= REG_H;
          rf_data_q <= hl_next_s[15:8];
        end
        ST_WB_H: begin
          state_q     <= ST_DONE;
          rf_sel_q    <= 3'b000;
          rf_data_q   <= 8'h00;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= op_is_rd(op_q) ? rdata_q : 8'h00;
          rsp_err_q   <= 1'b0;
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_data_q  <= 8'h00;
          rsp_err_q   <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          mem_rd_q    <= 1'b0;
          mem_wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.mem_wr       = mem_wr_q;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_write_sel = rf_sel_q;
  assign bus.rf_data      = rf_data_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_hl_mem_unit.sv
// Directed bench for hl_mem_unit: one task per scenario with hand-computed
// cycle counts, addresses and register-file writes.
module tb_hl_mem_unit;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  hl_mem_unit_if bus ();

  hl_mem_unit #(.MAX_WAIT(15), .WAIT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          o_rsp_cyc, o_rsp_cnt, o_rd_cnt, o_wr_cnt, o_rf_cnt, o_first_mem;
  logic [15:0] o_addr;
  logic [7:0]  o_wdata, o_rsp_data;
  logic        o_rsp_err, o_both, o_ready_after;
  logic [2:0]  o_rf_sel [4];
  logic [7:0]  o_rf_dat [4];

  // Issue one request and record what the unit does cycle by cycle (cycle 1 = first after accept)
  task automatic do_req(input logic [2:0] op, input logic [7:0] wd, input logic [15:0] hl,
                        input int zero_cycles, input logic [7:0] rd);
    int cyc;
    int waits;
    o_rsp_cyc = 0; o_rsp_cnt = 0; o_rd_cnt = 0; o_wr_cnt = 0; o_rf_cnt = 0; o_first_mem = 0;
    o_addr = 16'h0000; o_wdata = 8'h00; o_rsp_data = 8'h00; o_rsp_err = 1'b0;
    o_both = 1'b0; o_ready_after = 1'b0;
    for (int i = 0; i < 4; i++) begin o_rf_sel[i] = 3'b000; o_rf_dat[i] = 8'h00; end
    waits = 0;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_wdata = wd; bus.hl_in = hl;
    bus.mem_ready = 1'b0; bus.mem_rdata = rd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.hl_in = 16'hDEAD; bus.req_wdata = 8'hEE;
    cyc = 1;
    while (cyc < 40) begin
      if (bus.mem_rd) o_rd_cnt++;
      if (bus.mem_wr) o_wr_cnt++;
      if (bus.mem_rd && bus.mem_wr) o_both = 1'b1;
      if ((bus.mem_rd || bus.mem_wr) && o_first_mem == 0) begin
        o_first_mem = cyc; o_addr = bus.mem_addr; o_wdata = bus.mem_wdata;
      end
      if (bus.rf_we) begin
        if (o_rf_cnt < 4) begin o_rf_sel[o_rf_cnt] = bus.rf_write_sel; o_rf_dat[o_rf_cnt] = bus.rf_data; end
        o_rf_cnt++;
      end
      if (bus.rsp_valid) begin
        o_rsp_cnt++; o_rsp_cyc = cyc; o_rsp_data = bus.rsp_data; o_rsp_err = bus.rsp_err;
      end
      if (bus.mem_rd || bus.mem_wr) begin
        bus.mem_ready = (waits >= zero_cycles);
        waits++;
      end else begin
        bus.mem_ready = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (o_rsp_cnt > 0 && cyc == o_rsp_cyc + 1) begin
        o_ready_after = bus.req_ready;
        break;
      end
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 3'b000; bus.req_wdata = 8'h00; bus.hl_in = 16'h0000;
    bus.mem_rdata = 8'h00; bus.mem_ready = 1'b0;
    #12;
    n_chk++; if (bus.req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); else n_pass++;
    n_chk++; if ({bus.mem_rd, bus.mem_wr, bus.rf_we, bus.rsp_valid, bus.rsp_err} !== 5'b00000)
      $display("FAIL rst_ctrl: got %b want 00000", {bus.mem_rd, bus.mem_wr, bus.rf_we, bus.rsp_valid, bus.rsp_err}); else n_pass++;
    n_chk++; if ({bus.mem_addr, bus.mem_wdata, bus.rf_data, bus.rsp_data} !== 40'h0)
      $display("FAIL rst_data: got %h want 0", {bus.mem_addr, bus.mem_wdata, bus.rf_data, bus.rsp_data}); else n_pass++;
    #10 reset = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (bus.req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", bus.req_ready); else n_pass++;
  endtask

  task automatic test_read;
    do_req(3'b000, 8'h00, 16'h1234, 0, 8'h5A);
    n_chk++; if (o_first_mem !== 1) $display("FAIL rd_first_cycle: got %0d want 1", o_first_mem); else n_pass++;
    n_chk++; if (o_addr !== 16'h1234) $display("FAIL rd_addr: got %h want 1234", o_addr); else n_pass++;
    n_chk++; if (o_rd_cnt !== 1 || o_wr_cnt !== 0) $display("FAIL rd_strobes: got rd=%0d wr=%0d want rd=1 wr=0", o_rd_cnt, o_wr_cnt); else n_pass++;
    n_chk++; if (o_rsp_cyc !== 2) $display("FAIL rd_latency: got %0d want 2", o_rsp_cyc); else n_pass++;
    n_chk++; if (o_rsp_data !== 8'h5A || o_rsp_err !== 1'b0) $display("FAIL rd_rsp: got %h/%b want 5a/0", o_rsp_data, o_rsp_err); else n_pass++;
    n_chk++; if (o_rf_cnt !== 0) $display("FAIL rd_no_rf: got %0d want 0", o_rf_cnt); else n_pass++;
    n_chk++; if (o_ready_after !== 1'b1) $display("FAIL rd_ready_after: got %b want 1", o_ready_after); else n_pass++;
  endtask

  task automatic test_write_inc;
    do_req(3'b011, 8'hC3, 16'h20FF, 0, 8'h00);
    n_chk++; if (o_wr_cnt !== 1 || o_rd_cnt !== 0) $display("FAIL wrinc_strobes: got wr=%0d rd=%0d want wr=1 rd=0", o_wr_cnt, o_rd_cnt); else n_pass++;
    n_chk++; if (o_addr !== 16'h20FF || o_wdata !== 8'hC3) $display("FAIL wrinc_bus: got %h/%h want 20ff/c3", o_addr, o_wdata); else n_pass++;
    n_chk++; if (o_rf_cnt !== 2) $display("FAIL wrinc_rf_count: got %0d want 2", o_rf_cnt); else n_pass++;
    n_chk++; if (o_rf_sel[0] !== 3'b110 || o_rf_dat[0] !== 8'h00) $display("FAIL wrinc_rf_l: got %b/%h want 110/00", o_rf_sel[0], o_rf_dat[0]); else n_pass++;
    n_chk++; if (o_rf_sel[1] !== 3'b101 || o_rf_dat[1] !== 8'h21) $display("FAIL wrinc_rf_h: got %b/%h want 101/21", o_rf_sel[1], o_rf_dat[1]); else n_pass++;
    n_chk++; if (o_rsp_cyc !== 4 || o_rsp_data !== 8'h00) $display("FAIL wrinc_rsp: got cyc=%0d data=%h want cyc=4 data=00", o_rsp_cyc, o_rsp_data); else n_pass++;
    n_chk++; if (o_both !== 1'b0) $display("FAIL wrinc_excl: got %b want 0", o_both); else n_pass++;
  endtask

  task automatic test_incdec;
    do_req(3'b100, 8'h00, 16'hFFFF, 0, 8'h00);
    n_chk++; if (o_rf_cnt !== 2 || o_rf_dat[0] !== 8'h00 || o_rf_dat[1] !== 8'h00 || o_rf_sel[0] !== 3'b110)
      $display("FAIL inx_wrap: got n=%0d L=%h H=%h sel=%b want n=2 L=00 H=00 sel=110", o_rf_cnt, o_rf_dat[0], o_rf_dat[1], o_rf_sel[0]); else n_pass++;
    n_chk++; if (o_rsp_cyc !== 3 || o_first_mem !== 0) $display("FAIL inx_timing: got cyc=%0d mem=%0d want cyc=3 mem=0", o_rsp_cyc, o_first_mem); else n_pass++;
    do_req(3'b101, 8'h00, 16'h0000, 0, 8'h00);
    n_chk++; if (o_rf_cnt !== 2 || o_rf_dat[0] !== 8'hFF || o_rf_dat[1] !== 8'hFF || o_rf_sel[1] !== 3'b101)
      $display("FAIL dcx_wrap: got n=%0d L=%h H=%h sel=%b want n=2 L=ff H=ff sel=101", o_rf_cnt, o_rf_dat[0], o_rf_dat[1], o_rf_sel[1]); else n_pass++;
    n_chk++; if (o_rsp_cyc !== 3 || o_rsp_data !== 8'h00) $display("FAIL dcx_rsp: got cyc=%0d data=%h want cyc=3 data=00", o_rsp_cyc, o_rsp_data); else n_pass++;
    do_req(3'b110, 8'h00, 16'h1000, 0, 8'h77);
    n_chk++; if (o_rf_dat[0] !== 8'hFF || o_rf_dat[1] !== 8'h0F) $display("FAIL rddec_hl: got L=%h H=%h want L=ff H=0f", o_rf_dat[0], o_rf_dat[1]); else n_pass++;
    n_chk++; if (o_rsp_cyc !== 4 || o_rsp_data !== 8'h77) $display("FAIL rddec_rsp: got cyc=%0d data=%h want cyc=4 data=77", o_rsp_cyc, o_rsp_data); else n_pass++;
  endtask

  task automatic test_wait_states;
    do_req(3'b000, 8'h00, 16'h8001, 3, 8'hA5);
    n_chk++; if (o_rd_cnt !== 4) $display("FAIL wait_rd_held: got %0d want 4", o_rd_cnt); else n_pass++;
    n_chk++; if (o_rsp_cyc !== 5 || o_rsp_err !== 1'b0 || o_rsp_data !== 8'hA5)
      $display("FAIL wait_rsp: got cyc=%0d err=%b data=%h want cyc=5 err=0 data=a5", o_rsp_cyc, o_rsp_err, o_rsp_data); else n_pass++;
    do_req(3'b111, 8'h3C, 16'h0000, 2, 8'h00);
    n_chk++; if (o_wr_cnt !== 3 || o_wdata !== 8'h3C) $display("FAIL wrdec_wr: got n=%0d data=%h want n=3 data=3c", o_wr_cnt, o_wdata); else n_pass++;
    n_chk++; if (o_rsp_cyc !== 6 || o_rf_dat[0] !== 8'hFF || o_rf_dat[1] !== 8'hFF)
      $display("FAIL wrdec_rsp: got cyc=%0d L=%h H=%h want cyc=6 L=ff H=ff", o_rsp_cyc, o_rf_dat[0], o_rf_dat[1]); else n_pass++;
  endtask

  task automatic test_timeout;
    do_req(3'b010, 8'h00, 16'h3000, 99, 8'h99);
    n_chk++; if (o_rsp_cnt !== 1 || o_rsp_err !== 1'b1 || o_rsp_data !== 8'h00)
      $display("FAIL tmo_rsp: got n=%0d err=%b data=%h want n=1 err=1 data=00", o_rsp_cnt, o_rsp_err, o_rsp_data); else n_pass++;
    n_chk++; if (o_rf_cnt !== 0) $display("FAIL tmo_no_rf: got %0d want 0", o_rf_cnt); else n_pass++;
    n_chk++; if (o_rd_cnt !== 15 || o_rsp_cyc !== 16) $display("FAIL tmo_timing: got rd=%0d cyc=%0d want rd=15 cyc=16", o_rd_cnt, o_rsp_cyc); else n_pass++;
    n_chk++; if (o_ready_after !== 1'b1) $display("FAIL tmo_ready_after: got %b want 1", o_ready_after); else n_pass++;
  endtask

  task automatic test_reset_mid_and_busy;
    int rsp_n;
    int rf_n;
    logic [7:0] rdat;
    bus.req_valid = 1'b1; bus.req_op = 3'b001; bus.req_wdata = 8'h99; bus.hl_in = 16'h4000; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_chk++; if (bus.mem_wr !== 1'b1) $display("FAIL mid_wr_active: got %b want 1", bus.mem_wr); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_chk++; if (bus.mem_wr !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL mid_reset_drop: got wr=%b rdy=%b want wr=0 rdy=1", bus.mem_wr, bus.req_ready); else n_pass++;
    #3 reset = 1'b1;
    rsp_n = 0; rf_n = 0; rdat = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) rsp_n++;
      if (bus.rf_we) rf_n++;
    end
    n_chk++; if (rsp_n !== 0 || rf_n !== 0) $display("FAIL mid_no_wb: got rsp=%0d rf=%0d want 0/0", rsp_n, rf_n); else n_pass++;
    // A request arriving while busy must be dropped, not queued
    bus.req_valid = 1'b1; bus.req_op = 3'b000; bus.hl_in = 16'h0100; bus.mem_rdata = 8'h11;
    @(posedge clk); #1;
    n_chk++; if (bus.req_ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", bus.req_ready); else n_pass++;
    bus.req_op = 3'b100; bus.hl_in = 16'h2222; bus.mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      if (bus.rsp_valid) begin rsp_n++; rdat = bus.rsp_data; bus.req_valid = 1'b0; end
      if (bus.rf_we) rf_n++;
    end
    bus.req_valid = 1'b0;
    n_chk++; if (rsp_n !== 1 || rf_n !== 0 || rdat !== 8'h11)
      $display("FAIL busy_single_rsp: got rsp=%0d rf=%0d data=%h want 1/0/11", rsp_n, rf_n, rdat); else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_read();
    test_write_inc();
    test_incdec();
    test_wait_states();
    test_timeout();
    test_reset_mid_and_busy();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
